issue_scheduler: RTL

Issue scheduler for the out-of-order back end: each cycle it decides which reservation queues (integer, load/store, multiplier, divider) may issue their selected ready entry. It guarantees that results never collide on the single common data bus (CDB). It keeps a CDB slot-reservation shift register and a divider-busy counter. It also tells the CDB result mux which unit owns the bus in the current cycle. It sits between the four dispatch queues and the execution units.

---
 rtl/issue_scheduler.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/issue_scheduler.sv
// ---------------------------------------------------------------------------
// issue_scheduler
//
// Decides each cycle which reservation queues (integer, load/store,
// multiplier, divider) may issue. Results from all four execution units
// share one common data bus (CDB), so the scheduler tracks CDB slot
// reservations in a shift register. A unit with latency L is granted only
// when CDB slot t+L is free. A counter tracks occupancy of the non-pipelined
// divider. The oldest reservation slot names the unit that drives the CDB
// in the current cycle.
//
// Parameters:
//   MULT_LAT  multiplier issue-to-CDB latency (pipelined), 2 <= MULT_LAT < DIV_LAT
//   DIV_LAT   divider issue-to-CDB latency (non-pipelined)
//
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous active-high reset
//   ready_*          queue holds an issuable entry (int, lw_sw, mult, div)
//   issue_stall      branch stall, suppresses every grant
//   issue_*          combinational grant to the matching queue
//   div_busy         divider occupied by an earlier issue
//   cdb_owner        unit driving the CDB this cycle (00 int, 01 lw_sw, 10 mult, 11 div)
//   cdb_owner_valid  CDB carries a result this cycle
// ---------------------------------------------------------------------------
module issue_scheduler #(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ready_int,
    input  logic       ready_lw_sw,
    input  logic       ready_mult,
    input  logic       ready_div,
    input  logic       issue_stall,
    output logic       issue_int,
    output logic       issue_lw_sw,
    output logic       issue_mult,
    output logic       issue_div,
    output logic       div_busy,
    output logic [1:0] cdb_owner,
    output logic       cdb_owner_valid
);

    localparam int CNT_W = $clog2(DIV_LAT);

    localparam logic [1:0] CODE_INT  = 2'b00;
    localparam logic [1:0] CODE_LS   = 2'b01;
    localparam logic [1:0] CODE_MULT = 2'b10;
    localparam logic [1:0] CODE_DIV  = 2'b11;

    // rsv_vld[k] / rsv_code[k]: CDB slot k cycles from now is claimed by rsv_code[k]
    logic [DIV_LAT:0] rsv_vld;
    logic [1:0]       rsv_code [0:DIV_LAT];
    logic [DIV_LAT:0] rsv_vld_nxt;
    logic [1:0]       rsv_code_nxt [0:DIV_LAT];

    logic [CNT_W-1:0] div_cnt;
    logic [CNT_W-1:0] div_cnt_nxt;
    logic             rr_ptr;      // 0 = prefer int, 1 = prefer lw_sw
    logic             rr_ptr_nxt;

    logic allow;
    logic int_ok;
    logic ls_ok;

    assign div_busy        = (div_cnt != '0);
    assign cdb_owner       = rsv_code[0];
    assign cdb_owner_valid = rsv_vld[0];

    // Grant logic: int and lw_sw compete for slot 1; mult and div each look
    // at their own slot, so they are independent of the int/lw_sw choice.
    always_comb begin
        allow       = !issue_stall && !rst;
        int_ok      = ready_int   && !rsv_vld[1];
        ls_ok       = ready_lw_sw && !rsv_vld[1];
        issue_int   = allow && int_ok && (!ls_ok || !rr_ptr);
        issue_lw_sw = allow && ls_ok  && (!int_ok || rr_ptr);
        issue_mult  = allow && ready_mult && !rsv_vld[MULT_LAT];
        issue_div   = allow && ready_div && !div_busy && !rsv_vld[DIV_LAT];
    end

    // Next reservation state: shift one slot toward the bus, then claim the
    // slot for each grant. The claimed slot was checked free before the
    // grant, so the write never lands on a valid entry.
    always_comb begin
        rsv_vld_nxt = {1'b0, rsv_vld[DIV_LAT:1]};
        for (int k = 0; k < DIV_LAT; k++) begin
            rsv_code_nxt[k] = rsv_code[k+1];
        end
        rsv_code_nxt[DIV_LAT] = 2'b00;

        if (issue_int) begin
            rsv_vld_nxt[0]  = 1'b1;
            rsv_code_nxt[0] = CODE_INT;
        end
        if (issue_lw_sw) begin
            rsv_vld_nxt[0]  = 1'b1;
            rsv_code_nxt[0] = CODE_LS;
        end
        if (issue_mult) begin
            rsv_vld_nxt[MULT_LAT-1]  = 1'b1;
            rsv_code_nxt[MULT_LAT-1] = CODE_MULT;
        end
        if (issue_div) begin
            rsv_vld_nxt[DIV_LAT-1]  = 1'b1;
            rsv_code_nxt[DIV_LAT-1] = CODE_DIV;
        end
    end

    // Round-robin pointer and divider occupancy counter.
    always_comb begin
        rr_ptr_nxt = rr_ptr;
        if (issue_int) begin
            rr_ptr_nxt = 1'b1;
        end else if (issue_lw_sw) begin
            rr_ptr_nxt = 1'b0;
        end

        div_cnt_nxt = div_cnt;
        if (issue_div) begin
            div_cnt_nxt = CNT_W'(DIV_LAT - 1);
        end else if (div_cnt != '0) begin
            div_cnt_nxt = div_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsv_vld <= '0;
            for (int k = 0; k <= DIV_LAT; k++) begin
                rsv_code[k] <= 2'b00;
            end
            div_cnt <= '0;
            rr_ptr  <= 1'b0;
        end else begin
            rsv_vld <= rsv_vld_nxt;
            for (int k = 0; k <= DIV_LAT; k++) begin
                rsv_code[k] <= rsv_code_nxt[k];
            end
            div_cnt <= div_cnt_nxt;
            rr_ptr  <= rr_ptr_nxt;
        end
    end

endmodule
